// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared SoC bus: one grant at a time, held from begin to end/error.
// Define BUS_ARB_WATCHDOG_EN to add a watchdog that forces busError/endTransaction on hung transfers.
module bus_arbiter_rr #(
    parameter int NUM_MASTERS     = 4,
    parameter int WATCHDOG_CYCLES = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_MASTERS-1:0] req_i,
    output logic [NUM_MASTERS-1:0] grant_o,
    input  logic                   bus_beginTransaction_i,
    input  logic                   bus_endTransaction_i,
    input  logic                   bus_error_i,
    output logic                   bus_error_o,
    output logic                   bus_endTransaction_o,
    output logic                   active_o
);

    localparam int PTR_W = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2,
        TURN  = 2'd3
    } state_t;

    state_t                   state_r;
    state_t                   nextState_s;
    logic [NUM_MASTERS-1:0]   grant_r;
    logic [NUM_MASTERS-1:0]   grantNext_s;
    logic [PTR_W-1:0]         pointer_r;
    logic [PTR_W-1:0]         pointerNext_s;
    logic [PTR_W-1:0]         winner_s;
    logic                     active_r;
    logic                     anyReq_s;
    logic                     done_s;
    logic                     timeout_s;

    // Out-of-range configurations leave this named block as an elaboration marker.
    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || WATCHDOG_CYCLES < 2) begin : gBadConfig
    end

    function automatic logic [PTR_W-1:0] wrapInc(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(NUM_MASTERS - 1)) ? {PTR_W{1'b0}} : idx + PTR_W'(1);
    endfunction

    // First requester at or after ptr, wrapping through all masters once.
    function automatic logic [PTR_W-1:0] pickWinner(input logic [NUM_MASTERS-1:0] req,
                                                    input logic [PTR_W-1:0]       ptr);
        logic [PTR_W-1:0] idx;
        logic [PTR_W-1:0] win;
        logic             found;
        logic             hit;
        idx   = ptr;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            hit   = !found && req[idx];
            win   = hit ? idx : win;
            found = found | hit;
            idx   = wrapInc(idx);
        end
        return win;
    endfunction

    assign anyReq_s = |req_i;
    assign done_s   = bus_endTransaction_i | bus_error_i;
    assign winner_s = pickWinner(req_i, pointer_r);

`ifdef BUS_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(WATCHDOG_CYCLES);

    logic [CNT_W-1:0] cnt_r;
    logic             wdError_r;
    logic             wdEnd_r;

    assign timeout_s = (state_r == BUSY) && (cnt_r == CNT_W'(WATCHDOG_CYCLES - 1)) && !done_s;

    // Watchdog counter restarts outside BUSY; timeout pulses last exactly one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r     <= {CNT_W{1'b0}};
            wdError_r <= 1'b0;
            wdEnd_r   <= 1'b0;
        end else begin
            cnt_r     <= (state_r == BUSY) ? cnt_r + CNT_W'(1) : {CNT_W{1'b0}};
            wdError_r <= timeout_s;
            wdEnd_r   <= timeout_s;
        end
    end

    assign bus_error_o          = wdError_r;
    assign bus_endTransaction_o = wdEnd_r;
`else
    assign timeout_s            = 1'b0;
    assign bus_error_o          = 1'b0;
    assign bus_endTransaction_o = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            grant_r   <= {NUM_MASTERS{1'b0}};
            pointer_r <= {PTR_W{1'b0}};
            active_r  <= 1'b0;
        end else begin
            state_r   <= nextState_s;
            grant_r   <= grantNext_s;
            pointer_r <= pointerNext_s;
            active_r  <= (nextState_s != IDLE);
        end
    end

    // Next-state logic; begin beats a same-cycle request drop in GRANT.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (anyReq_s) nextState_s = GRANT;
                else          nextState_s = IDLE;
            end
            GRANT: begin
                if (bus_beginTransaction_i)     nextState_s = BUSY;
                else if (!(|(req_i & grant_r))) nextState_s = IDLE;
                else                            nextState_s = GRANT;
            end
            BUSY: begin
                if (done_s || timeout_s) nextState_s = TURN;
                else                     nextState_s = BUSY;
            end
            TURN:    nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    // Grant and pointer updates; the pointer moves as soon as a winner is chosen.
    always_comb begin
        grantNext_s   = grant_r;
        pointerNext_s = pointer_r;
        case (state_r)
            IDLE: begin
                if (anyReq_s) begin
                    grantNext_s   = {{(NUM_MASTERS - 1){1'b0}}, 1'b1} << winner_s;
                    pointerNext_s = wrapInc(winner_s);
                end else begin
                    grantNext_s   = {NUM_MASTERS{1'b0}};
                end
            end
            GRANT, BUSY: begin
                if (nextState_s == IDLE || nextState_s == TURN) grantNext_s = {NUM_MASTERS{1'b0}};
                else                                            grantNext_s = grant_r;
            end
            default: grantNext_s = {NUM_MASTERS{1'b0}};
        endcase
    end

    assign grant_o  = grant_r;
    assign active_o = active_r;

endmodule
